// File: rtl/approx_add_share_pkg.sv
// Shared constants, types and the round-robin pick helper for the
// approximate-adder sharing controller.
package approx_add_share_pkg;

  localparam int W_DEF    = 8;
  localparam int NREQ_DEF = 4;
  localparam int IDW_DEF  = $clog2(NREQ_DEF);
  localparam int MAX_NREQ = 8;

  typedef logic [IDW_DEF-1:0] req_id_t;
  typedef logic [W_DEF:0]     sum_t;

  // First set bit of valid at or above ptr, wrapping within the low n bits.
  function automatic logic [MAX_NREQ-1:0] rr_pick(
    input logic [MAX_NREQ-1:0] valid,
    input logic [2:0]          ptr,
    input int                  n
  );
    logic [MAX_NREQ-1:0] g;
    logic                found;
    int                  idx;
    g     = 8'h00;
    found = 1'b0;
    for (int k = 0; k < MAX_NREQ; k++) begin
      idx = int'({29'd0, ptr}) + k;
      if (idx >= n) begin
        idx = idx - n;
      end else begin
        idx = idx;
      end
      if ((k < n) && !found && valid[idx[2:0]]) begin
        g[idx[2:0]] = 1'b1;
        found       = 1'b1;
      end else begin
        found = found;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/approx_add_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter; the rotating pointer lives in the parent.
module rr_arbiter
  import approx_add_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any
);

  logic [MAX_NREQ-1:0] valid_ext_s;
  logic [2:0]          ptr_ext_s;
  logic [MAX_NREQ-1:0] pick_s;

  // Widen to the helper's fixed width; masked requests never win.
  always_comb begin
    valid_ext_s             = 8'h00;
    valid_ext_s[NREQ-1:0]   = req & {NREQ{enable}};
    ptr_ext_s               = 3'd0;
    ptr_ext_s[IDW-1:0]      = ptr;
    pick_s                  = rr_pick(valid_ext_s, ptr_ext_s, NREQ);
  end

  // One-hot grant to binary index.
  always_comb begin
    grant     = pick_s[NREQ-1:0];
    any       = |pick_s;
    grant_idx = {IDW{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      grant_idx = grant_idx | (pick_s[i] ? IDW'(i) : {IDW{1'b0}});
    end
  end

endmodule

// File: rtl/approx_add_share_ctrl.sv
// Two-stage controller time-sharing one external approximate adder among
// NREQ requesters: operand register feeds the adder, response register holds its sum.
module approx_add_share_ctrl
  import approx_add_share_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int W     = W_DEF,
  parameter int IDW   = $clog2(NREQ),
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [W-1:0]      add_a,
  output logic [W-1:0]      add_b,
  input  logic [W:0]        add_o,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [W:0]        resp_sum,
  output logic [IDW-1:0]    resp_id,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  logic              op_v_r;
  logic [W-1:0]      op_a_r;
  logic [W-1:0]      op_b_r;
  logic [IDW-1:0]    op_id_r;
  logic              resp_valid_r;
  logic [W:0]        resp_sum_r;
  logic [IDW-1:0]    resp_id_r;
  logic [IDW-1:0]    rr_ptr_r;
  logic [CNT_W-1:0]  op_count_r;

  logic              res_load_s;
  logic              op_load_s;
  logic              resp_fire_s;
  logic              arb_en_s;
  logic [NREQ-1:0]   grant_s;
  logic [IDW-1:0]    grant_idx_s;
  logic              grant_any_s;
  logic [W-1:0]      sel_a_s;
  logic [W-1:0]      sel_b_s;
  logic [IDW-1:0]    ptr_next_s;

  // Pipeline advance conditions; reset gating keeps req_ready low while rst_n is asserted.
  always_comb begin
    resp_fire_s = resp_valid_r & resp_ready;
    res_load_s  = op_v_r & (~resp_valid_r | resp_ready);
    op_load_s   = ~op_v_r | res_load_s;
    arb_en_s    = op_load_s & rst_n;
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_r),
    .enable    (arb_en_s),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .any       (grant_any_s)
  );

  // Winner's operand slices and the pointer one past the winner.
  always_comb begin
    sel_a_s = {W{1'b0}};
    sel_b_s = {W{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      sel_a_s = sel_a_s | (grant_s[i] ? req_a[i*W +: W] : {W{1'b0}});
      sel_b_s = sel_b_s | (grant_s[i] ? req_b[i*W +: W] : {W{1'b0}});
    end
    if (grant_idx_s == IDW'(NREQ - 1)) begin
      ptr_next_s = {IDW{1'b0}};
    end else begin
      ptr_next_s = grant_idx_s + {{(IDW-1){1'b0}}, 1'b1};
    end
  end

  // Operand stage: operands only change when the stage drains or is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_v_r   <= 1'b0;
      op_a_r   <= {W{1'b0}};
      op_b_r   <= {W{1'b0}};
      op_id_r  <= {IDW{1'b0}};
      rr_ptr_r <= {IDW{1'b0}};
    end else if (op_load_s) begin
      if (grant_any_s) begin
        op_v_r   <= 1'b1;
        op_a_r   <= sel_a_s;
        op_b_r   <= sel_b_s;
        op_id_r  <= grant_idx_s;
        rr_ptr_r <= ptr_next_s;
      end else begin
        op_v_r <= 1'b0;
      end
    end else begin
      op_v_r <= op_v_r;
    end
  end

  // Response stage: capture adder output only while the operand stage is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_r <= 1'b0;
      resp_sum_r   <= {(W+1){1'b0}};
      resp_id_r    <= {IDW{1'b0}};
    end else if (res_load_s) begin
      resp_valid_r <= 1'b1;
      resp_sum_r   <= add_o;
      resp_id_r    <= op_id_r;
    end else if (resp_fire_s) begin
      resp_valid_r <= 1'b0;
    end else begin
      resp_valid_r <= resp_valid_r;
    end
  end

  // Saturating completed-response counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_r <= {CNT_W{1'b0}};
    end else if (resp_fire_s && (op_count_r != {CNT_W{1'b1}})) begin
      op_count_r <= op_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      op_count_r <= op_count_r;
    end
  end

  // Output mapping.
  always_comb begin
    req_ready  = grant_s;
    add_a      = op_a_r;
    add_b      = op_b_r;
    resp_valid = resp_valid_r;
    resp_sum   = resp_sum_r;
    resp_id    = resp_id_r;
    busy       = op_v_r | resp_valid_r;
    op_count   = op_count_r;
  end

endmodule

// File: tb/tb_approx_add_share_ctrl.sv
// Directed, table-driven bench for approx_add_share_ctrl with an exact adder
// attached; a second narrow-counter instance covers counter saturation.
module tb_approx_add_share_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic [7:0]  add_a, add_b;
  logic [8:0]  add_o;
  logic        resp_valid, resp_ready;
  logic [8:0]  resp_sum;
  logic [1:0]  resp_id;
  logic        busy;
  logic [15:0] op_count;

  logic [1:0]  s_valid;
  logic [15:0] s_a, s_b;
  logic [1:0]  s_ready;
  logic [7:0]  s_add_a, s_add_b;
  logic [8:0]  s_add_o;
  logic        s_rv, s_rrdy;
  logic [8:0]  s_sum;
  logic [0:0]  s_id;
  logic        s_busy;
  logic [2:0]  s_cnt;

  always #5 clk = ~clk;

  assign add_o   = {1'b0, add_a} + {1'b0, add_b};
  assign s_add_o = {1'b0, s_add_a} + {1'b0, s_add_b};

  approx_add_share_ctrl #(.NREQ(4), .W(8), .IDW(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .add_a(add_a), .add_b(add_b), .add_o(add_o),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_sum(resp_sum),
    .resp_id(resp_id), .busy(busy), .op_count(op_count)
  );

  approx_add_share_ctrl #(.NREQ(2), .W(8), .IDW(1), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(s_valid), .req_a(s_a), .req_b(s_b),
    .req_ready(s_ready), .add_a(s_add_a), .add_b(s_add_b), .add_o(s_add_o),
    .resp_valid(s_rv), .resp_ready(s_rrdy), .resp_sum(s_sum),
    .resp_id(s_id), .busy(s_busy), .op_count(s_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] valid;
    logic       rrdy;
    logic [3:0] exp_ready;
    logic       exp_rv;
    logic [8:0] exp_sum;
    logic [1:0] exp_id;
    logic       exp_busy;
    logic       chk_add;
    logic [7:0] exp_add_a;
  } vec_t;

  vec_t tbl[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Operand sets used by the table: sums 11, 22, 33, 505 for ids 0..3.
    tbl.push_back('{4'hF, 1'b1, 4'b0010, 1'b0, 9'd0,   2'd0, 1'b0, 1'b0, 8'd0});
    tbl.push_back('{4'hF, 1'b1, 4'b0100, 1'b0, 9'd0,   2'd0, 1'b1, 1'b1, 8'd20});
    tbl.push_back('{4'hF, 1'b1, 4'b1000, 1'b1, 9'd22,  2'd1, 1'b1, 1'b1, 8'd30});
    tbl.push_back('{4'hF, 1'b1, 4'b0001, 1'b1, 9'd33,  2'd2, 1'b1, 1'b1, 8'd250});
    tbl.push_back('{4'hF, 1'b1, 4'b0010, 1'b1, 9'd505, 2'd3, 1'b1, 1'b1, 8'd10});
    tbl.push_back('{4'h0, 1'b1, 4'b0000, 1'b1, 9'd11,  2'd0, 1'b1, 1'b1, 8'd20});
    tbl.push_back('{4'h0, 1'b1, 4'b0000, 1'b1, 9'd22,  2'd1, 1'b1, 1'b0, 8'd0});
    tbl.push_back('{4'h0, 1'b1, 4'b0000, 1'b0, 9'd0,   2'd0, 1'b0, 1'b0, 8'd0});
    // Backpressure: resp_ready low for five cycles, two ops absorbed.
    tbl.push_back('{4'hF, 1'b0, 4'b0100, 1'b0, 9'd0,   2'd0, 1'b0, 1'b0, 8'd0});
    tbl.push_back('{4'hF, 1'b0, 4'b1000, 1'b0, 9'd0,   2'd0, 1'b1, 1'b1, 8'd30});
    tbl.push_back('{4'hF, 1'b0, 4'b0000, 1'b1, 9'd33,  2'd2, 1'b1, 1'b1, 8'd250});
    tbl.push_back('{4'hF, 1'b0, 4'b0000, 1'b1, 9'd33,  2'd2, 1'b1, 1'b1, 8'd250});
    tbl.push_back('{4'hF, 1'b0, 4'b0000, 1'b1, 9'd33,  2'd2, 1'b1, 1'b1, 8'd250});
    tbl.push_back('{4'hF, 1'b1, 4'b0001, 1'b1, 9'd33,  2'd2, 1'b1, 1'b1, 8'd250});
    tbl.push_back('{4'hF, 1'b1, 4'b0010, 1'b1, 9'd505, 2'd3, 1'b1, 1'b1, 8'd10});
    tbl.push_back('{4'h0, 1'b1, 4'b0000, 1'b1, 9'd11,  2'd0, 1'b1, 1'b1, 8'd20});
    tbl.push_back('{4'h0, 1'b1, 4'b0000, 1'b1, 9'd22,  2'd1, 1'b1, 1'b0, 8'd0});
    tbl.push_back('{4'h0, 1'b1, 4'b0000, 1'b0, 9'd0,   2'd0, 1'b0, 1'b0, 8'd0});
    // Requests only on 1 and 3 with pointer at 2.
    tbl.push_back('{4'hA, 1'b1, 4'b1000, 1'b0, 9'd0,   2'd0, 1'b0, 1'b0, 8'd0});
    tbl.push_back('{4'hA, 1'b1, 4'b0010, 1'b0, 9'd0,   2'd0, 1'b1, 1'b1, 8'd250});
    tbl.push_back('{4'hA, 1'b1, 4'b1000, 1'b1, 9'd505, 2'd3, 1'b1, 1'b1, 8'd20});
    tbl.push_back('{4'h0, 1'b1, 4'b0000, 1'b1, 9'd22,  2'd1, 1'b1, 1'b1, 8'd250});
    tbl.push_back('{4'h0, 1'b1, 4'b0000, 1'b1, 9'd505, 2'd3, 1'b1, 1'b0, 8'd0});
    tbl.push_back('{4'h0, 1'b1, 4'b0000, 1'b0, 9'd0,   2'd0, 1'b0, 1'b0, 8'd0});

    rst_n      = 1'b0;
    req_valid  = 4'hF;
    req_a      = {8'd250, 8'd30, 8'd20, 8'd200};
    req_b      = {8'd255, 8'd3, 8'd2, 8'd100};
    resp_ready = 1'b1;
    s_valid    = 2'b00;
    s_a        = {8'd5, 8'd7};
    s_b        = {8'd3, 8'd0};
    s_rrdy     = 1'b1;

    // Reset state, with requests asserted to confirm req_ready is held low.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_resp_sum", 32'(resp_sum), 32'd0);
    chk("rst_add_a", 32'(add_a), 32'd0);
    req_valid = 4'b0000;
    rst_n     = 1'b1;
    tick();

    // Single request on requester 0: 200 + 100.
    req_valid = 4'b0001;
    #1;
    chk("single_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("single_add_a", 32'(add_a), 32'd200);
    chk("single_add_b", 32'(add_b), 32'd100);
    chk("single_rv_t1", 32'(resp_valid), 32'd0);
    tick();
    chk("single_rv_t2", 32'(resp_valid), 32'd1);
    chk("single_sum", 32'(resp_sum), 32'd300);
    chk("single_id", 32'(resp_id), 32'd0);
    tick();
    chk("single_rv_done", 32'(resp_valid), 32'd0);
    chk("single_count", 32'(op_count), 32'd1);
    chk("single_busy", 32'(busy), 32'd0);

    // Table-driven streaming, backpressure and sparse-request rows.
    req_a = {8'd250, 8'd30, 8'd20, 8'd10};
    req_b = {8'd255, 8'd3, 8'd2, 8'd1};
    for (int r = 0; r < tbl.size(); r++) begin
      req_valid  = tbl[r].valid;
      resp_ready = tbl[r].rrdy;
      #1;
      chk($sformatf("row%0d_ready", r), 32'(req_ready), 32'(tbl[r].exp_ready));
      chk($sformatf("row%0d_rv", r), 32'(resp_valid), 32'(tbl[r].exp_rv));
      chk($sformatf("row%0d_busy", r), 32'(busy), 32'(tbl[r].exp_busy));
      if (tbl[r].exp_rv) begin
        chk($sformatf("row%0d_sum", r), 32'(resp_sum), 32'(tbl[r].exp_sum));
        chk($sformatf("row%0d_id", r), 32'(resp_id), 32'(tbl[r].exp_id));
      end
      if (tbl[r].chk_add) begin
        chk($sformatf("row%0d_add_a", r), 32'(add_a), 32'(tbl[r].exp_add_a));
      end
      tick();
    end
    chk("table_count", 32'(op_count), 32'd13);

    // Fill both stages, then assert reset between clock edges.
    req_valid  = 4'hF;
    resp_ready = 1'b0;
    #1;
    chk("mr_ready0", 32'(req_ready), 32'b0001);
    tick();
    chk("mr_ready1", 32'(req_ready), 32'b0010);
    tick();
    chk("mr_full_ready", 32'(req_ready), 32'b0000);
    chk("mr_full_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_rv_drop", 32'(resp_valid), 32'd0);
    chk("mr_busy_drop", 32'(busy), 32'd0);
    chk("mr_ready_drop", 32'(req_ready), 32'd0);
    chk("mr_count", 32'(op_count), 32'd0);
    req_valid  = 4'h0;
    resp_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("mr_post%0d_rv", k), 32'(resp_valid), 32'd0);
      tick();
    end

    // Saturation on the 3-bit counter instance, two requesters streaming.
    s_valid = 2'b11;
    for (int k = 0; k < 15; k++) begin
      #1;
      if (k == 0) chk("sat_ready0", 32'(s_ready), 32'b01);
      chk($sformatf("sat%0d_count", k), 32'(s_cnt), (k < 3) ? 32'd0 : ((k - 2 > 7) ? 32'd7 : 32'(k - 2)));
      if (k >= 2) begin
        chk($sformatf("sat%0d_id", k), 32'(s_id), 32'((k - 2) % 2));
        chk($sformatf("sat%0d_sum", k), 32'(s_sum), ((k - 2) % 2 == 0) ? 32'd7 : 32'd8);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
